// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus: two write requesters (A = ALU, B = memory load) and the register-file write port.
// The master modport is the requester/regfile side; the slave modport is the arbiter.
interface regfile_wb_arbiter_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 3
);
    logic          a_valid;
    logic [AW-1:0] a_adr;
    logic [DW-1:0] a_data;
    logic          a_ready;
    logic          b_valid;
    logic [AW-1:0] b_adr;
    logic [DW-1:0] b_data;
    logic          b_ready;
    logic          wr_en;
    logic [AW-1:0] wr_adr;
    logic [DW-1:0] wr_data;

    modport master (
        output a_valid, a_adr, a_data, b_valid, b_adr, b_data,
        input  a_ready, b_ready, wr_en, wr_adr, wr_data
    );

    modport slave (
        input  a_valid, a_adr, a_data, b_valid, b_adr, b_data,
        output a_ready, b_ready, wr_en, wr_adr, wr_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter merging two writeback requesters onto one registered register-file write port.
// Optional pending-register scoreboard (busy flags) is built when WB_SCOREBOARD_EN is defined.
module regfile_wb_arbiter #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus,
    input  logic                 claim_en,
    input  logic [AW-1:0]        claim_adr,
    output logic [(1<<AW)-1:0]   busy,
    input  logic                 stall_clr,
    output logic [7:0]           stall_cnt
);
    localparam logic GntA = 1'b0;
    localparam logic GntB = 1'b1;

    logic          r_last_gnt;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_adr;
    logic [DW-1:0] r_wr_data;
    logic [7:0]    r_stall_cnt;

    logic          w_a_ready;
    logic          w_b_ready;
    logic          w_xfer;
    logic          w_stall;
    logic [AW-1:0] w_wr_adr_d;
    logic [DW-1:0] w_wr_data_d;

    // On conflict the requester that did not win last time goes first.
    always_comb begin
        w_a_ready = rst_n && bus.a_valid && (!bus.b_valid || (r_last_gnt == GntB));
        w_b_ready = rst_n && bus.b_valid && !w_a_ready;
    end

    assign w_xfer      = w_a_ready || w_b_ready;
    assign w_stall     = (bus.a_valid && !w_a_ready) || (bus.b_valid && !w_b_ready);
    assign w_wr_adr_d  = w_a_ready ? bus.a_adr  : bus.b_adr;
    assign w_wr_data_d = w_a_ready ? bus.a_data : bus.b_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= GntB;
            r_wr_en    <= 1'b0;
            r_wr_adr   <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en <= w_xfer;
            if (w_xfer) begin
                r_last_gnt <= w_b_ready ? GntB : GntA;
                r_wr_adr   <= w_wr_adr_d;
                r_wr_data  <= w_wr_data_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (stall_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 8'hFF)) begin
            r_stall_cnt <= r_stall_cnt + 8'd1;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [(1<<AW)-1:0] r_busy;
    logic [(1<<AW)-1:0] w_busy_d;

    // A claim landing on the same edge as the clearing write wins: the new producer is still pending.
    always_comb begin
        w_busy_d = r_busy;
        if (w_xfer) begin
            w_busy_d[w_wr_adr_d] = 1'b0;
        end
        if (claim_en) begin
            w_busy_d[claim_adr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_d;
        end
    end

    assign busy = r_busy;
`else
    logic w_unused_claim;
    assign w_unused_claim = ^{claim_en, claim_adr};
    assign busy           = '0;
`endif

    assign bus.a_ready = w_a_ready;
    assign bus.b_ready = w_b_ready;
    assign bus.wr_en   = r_wr_en;
    assign bus.wr_adr  = r_wr_adr;
    assign bus.wr_data = r_wr_data;
    assign stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand sequences for corner cases,
// then random traffic against a transaction-level reference model.
module tb_regfile_wb_arbiter;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       claim_en = 1'b0;
    logic [2:0] claim_adr = '0;
    logic [7:0] busy;
    logic       stall_clr = 1'b0;
    logic [7:0] stall_cnt;

    int n_checks = 0;
    int n_err = 0;

    regfile_wb_arbiter_if #(.DW(DW), .AW(AW)) bus_if ();

    regfile_wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .claim_en  (claim_en),
        .claim_adr (claim_adr),
        .busy      (busy),
        .stall_clr (stall_clr),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        bit         av;
        logic [2:0] aadr;
        logic [15:0] adata;
        bit         bv;
        logic [2:0] badr;
        logic [15:0] bdata;
        bit         ar;
        bit         br;
        bit         wen;
        logic [2:0] wadr;
        logic [15:0] wdata;
        logic [7:0] stall;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input bit av, input logic [2:0] aa, input logic [15:0] ad,
                             input bit bv, input logic [2:0] ba, input logic [15:0] bd);
        bus_if.a_valid = av;
        bus_if.a_adr   = aa;
        bus_if.a_data  = ad;
        bus_if.b_valid = bv;
        bus_if.b_adr   = ba;
        bus_if.b_data  = bd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive_req(0, 0, 0, 0, 0, 0);
        claim_en  = 1'b0;
        stall_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model state (values the registered outputs must show after the next edge)
    bit          m_last_b;
    bit          m_wen;
    logic [2:0]  m_wadr;
    logic [15:0] m_wdata;
    int          m_stall;
    logic [7:0]  m_busy;

    initial begin
        drive_req(0, 0, 0, 0, 0, 0);

        tbl[0]  = '{1, 1, 3'd2, 16'h1234, 0, 3'd0, 16'h0000, 1, 0, 0, 3'd0, 16'h0000, 8'd0};
        tbl[1]  = '{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 1, 3'd2, 16'h1234, 8'd0};
        tbl[2]  = '{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 0, 3'd2, 16'h1234, 8'd0};
        tbl[3]  = '{1, 1, 3'd1, 16'h0008, 1, 3'd1, 16'h00FF, 1, 0, 0, 3'd0, 16'h0000, 8'd0};
        tbl[4]  = '{0, 0, 3'd0, 16'h0000, 1, 3'd1, 16'h00FF, 0, 1, 1, 3'd1, 16'h0008, 8'd1};
        tbl[5]  = '{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 1, 3'd1, 16'h00FF, 8'd1};
        tbl[6]  = '{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 0, 3'd1, 16'h00FF, 8'd1};
        tbl[7]  = '{0, 1, 3'd3, 16'hA001, 1, 3'd4, 16'hB001, 1, 0, 0, 3'd1, 16'h00FF, 8'd1};
        tbl[8]  = '{0, 1, 3'd3, 16'hA002, 1, 3'd4, 16'hB001, 0, 1, 1, 3'd3, 16'hA001, 8'd2};
        tbl[9]  = '{0, 1, 3'd3, 16'hA002, 1, 3'd4, 16'hB002, 1, 0, 1, 3'd4, 16'hB001, 8'd3};
        tbl[10] = '{0, 1, 3'd3, 16'hA003, 1, 3'd4, 16'hB002, 0, 1, 1, 3'd3, 16'hA002, 8'd4};
        tbl[11] = '{0, 1, 3'd3, 16'hA003, 1, 3'd4, 16'hB003, 1, 0, 1, 3'd4, 16'hB002, 8'd5};
        tbl[12] = '{0, 0, 3'd0, 16'h0000, 1, 3'd4, 16'hB003, 0, 1, 1, 3'd3, 16'hA003, 8'd6};
        tbl[13] = '{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 1, 3'd4, 16'hB003, 8'd6};
        tbl[14] = '{0, 0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 0, 3'd4, 16'hB003, 8'd6};

        for (int i = 0; i < 15; i++) begin
            if (tbl[i].rst) do_reset();
            else @(negedge clk);
            drive_req(tbl[i].av, tbl[i].aadr, tbl[i].adata, tbl[i].bv, tbl[i].badr, tbl[i].bdata);
            #1;
            check($sformatf("tbl[%0d].a_ready", i), bus_if.a_ready, tbl[i].ar);
            check($sformatf("tbl[%0d].b_ready", i), bus_if.b_ready, tbl[i].br);
            check($sformatf("tbl[%0d].wr_en", i), bus_if.wr_en, tbl[i].wen);
            check($sformatf("tbl[%0d].wr_adr", i), bus_if.wr_adr, tbl[i].wadr);
            check($sformatf("tbl[%0d].wr_data", i), bus_if.wr_data, tbl[i].wdata);
            check($sformatf("tbl[%0d].stall_cnt", i), stall_cnt, tbl[i].stall);
            check($sformatf("tbl[%0d].busy", i), busy, 8'h00);
        end

        // Saturation: constant conflict for 300 cycles, then clear while still conflicting
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive_req(1, 3'($urandom), 16'($urandom), 1, 3'($urandom), 16'($urandom));
            @(negedge clk);
        end
        #1 check("sat.stall_cnt", stall_cnt, 8'd255);
        @(negedge clk);
        #1 check("sat.hold", stall_cnt, 8'd255);
        stall_clr = 1'b1;
        @(negedge clk);
        stall_clr = 1'b0;
        #1 check("sat.clr", stall_cnt, 8'd0);
        @(negedge clk);
        #1 check("sat.after_clr", stall_cnt, 8'd1);

        // Reset landing between a transfer and its write cycle
        drive_req(1, 3'd6, 16'hBEEF, 0, 0, 0);
        #1 check("rstmid.a_ready_pre", bus_if.a_ready, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rstmid.wr_en", bus_if.wr_en, 1'b0);
        check("rstmid.wr_adr", bus_if.wr_adr, 3'd0);
        check("rstmid.wr_data", bus_if.wr_data, 16'h0000);
        check("rstmid.a_ready", bus_if.a_ready, 1'b0);
        check("rstmid.stall_cnt", stall_cnt, 8'd0);
        check("rstmid.busy", busy, 8'h00);
        @(negedge clk);
        #1 check("rstmid.wr_en_hold", bus_if.wr_en, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rstmid.a_ready_release", bus_if.a_ready, 1'b1);
        @(negedge clk);
        drive_req(0, 0, 0, 0, 0, 0);
        #1;
        check("rstmid.post_wr_en", bus_if.wr_en, 1'b1);
        check("rstmid.post_wr_data", bus_if.wr_data, 16'hBEEF);

        // Scoreboard behaviour
        do_reset();
        claim_en  = 1'b1;
        claim_adr = 3'd5;
        @(negedge clk);
        claim_en = 1'b0;
        drive_req(0, 0, 0, 1, 3'd5, 16'h0055);
`ifdef WB_SCOREBOARD_EN
        #1 check("sb.claim", busy, 8'h20);
        @(negedge clk);
        drive_req(0, 0, 0, 0, 0, 0);
        #1;
        check("sb.clear_wr_en", bus_if.wr_en, 1'b1);
        check("sb.clear", busy, 8'h00);
        drive_req(0, 0, 0, 1, 3'd5, 16'h0066);
        claim_en  = 1'b1;
        claim_adr = 3'd5;
        @(negedge clk);
        claim_en = 1'b0;
        drive_req(0, 0, 0, 0, 0, 0);
        #1;
        check("sb.same_edge_wr_en", bus_if.wr_en, 1'b1);
        check("sb.same_edge", busy, 8'h20);
`else
        #1 check("nosb.claim", busy, 8'h00);
        @(negedge clk);
        drive_req(0, 0, 0, 0, 0, 0);
        #1 check("nosb.after_write", busy, 8'h00);
`endif

        // Random traffic against the reference model
        do_reset();
        m_last_b = 1'b1;
        m_wen    = 1'b0;
        m_wadr   = '0;
        m_wdata  = '0;
        m_stall  = 0;
        m_busy   = '0;
        begin
            bit          a_pend = 0, b_pend = 0;
            logic [2:0]  a_adr = 0, b_adr = 0;
            logic [15:0] a_dat = 0, b_dat = 0;
            bit          win_a, win_b;
            for (int cyc = 0; cyc < 400; cyc++) begin
                if (cyc != 0) @(negedge clk);
                if (!a_pend && ($urandom % 3 != 0)) begin
                    a_pend = 1; a_adr = 3'($urandom); a_dat = 16'($urandom);
                end
                if (!b_pend && ($urandom % 3 != 0)) begin
                    b_pend = 1; b_adr = 3'($urandom); b_dat = 16'($urandom);
                end
                drive_req(a_pend, a_adr, a_dat, b_pend, b_adr, b_dat);
                stall_clr = ($urandom % 25 == 0);
                claim_en  = ($urandom % 4 == 0);
                claim_adr = 3'($urandom);

                // Winner: a lone requester, or on conflict whoever did not win last time
                if (a_pend && b_pend) begin
                    win_a = m_last_b;
                    win_b = !m_last_b;
                end else begin
                    win_a = a_pend;
                    win_b = b_pend;
                end

                #1;
                check($sformatf("rnd[%0d].a_ready", cyc), bus_if.a_ready, win_a);
                check($sformatf("rnd[%0d].b_ready", cyc), bus_if.b_ready, win_b);
                check($sformatf("rnd[%0d].wr_en", cyc), bus_if.wr_en, m_wen);
                check($sformatf("rnd[%0d].wr_adr", cyc), bus_if.wr_adr, m_wadr);
                check($sformatf("rnd[%0d].wr_data", cyc), bus_if.wr_data, m_wdata);
                check($sformatf("rnd[%0d].stall_cnt", cyc), stall_cnt, m_stall);
                check($sformatf("rnd[%0d].busy", cyc), busy, m_busy);

                m_wen = win_a || win_b;
                if (win_a) begin
                    m_wadr = a_adr; m_wdata = a_dat; m_last_b = 0;
                end else if (win_b) begin
                    m_wadr = b_adr; m_wdata = b_dat; m_last_b = 1;
                end
                if (stall_clr) m_stall = 0;
                else if ((a_pend && !win_a) || (b_pend && !win_b)) m_stall = (m_stall < 255) ? m_stall + 1 : 255;
`ifdef WB_SCOREBOARD_EN
                if (m_wen) m_busy[m_wadr] = 1'b0;
                if (claim_en) m_busy[claim_adr] = 1'b1;
`endif
                if (win_a) a_pend = 0;
                if (win_b) b_pend = 0;
            end
        end
        @(negedge clk);
        drive_req(0, 0, 0, 0, 0, 0);
        claim_en  = 1'b0;
        stall_clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
